// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: default operand width and the
// controller state encoding common to the modular blocks.
package rsa_pkg;

  localparam int RSA_WIDTH = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FINISH
  } modprod_state_e;

endpackage

// File: rtl/modulo_product_if.sv
// Start/finish handshake bundle for modulo_product. The same shape is
// used by the Montgomery multiplier so a single controller can drive both.
interface modulo_product_if
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
);

  logic             i_start;
  logic [WIDTH-1:0] i_n;
  logic [WIDTH-1:0] i_y;
  logic [WIDTH-1:0] o_result;
  logic             o_finished;
  logic             o_busy;

  modport master (
    output i_start, i_n, i_y,
    input  o_result, o_finished, o_busy
  );

  modport slave (
    input  i_start, i_n, i_y,
    output o_result, o_finished, o_busy
  );

endinterface

// File: rtl/modulo_product_mod_double.sv
// One modular doubling step: result = (2*t) mod n, assuming t < n.
// With t < n, 2t < 2n, so a single conditional subtract is enough.
module mod_double #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH:0] t2;
  logic [WIDTH:0] n_ext;

  // Double in WIDTH+1 bits so the shifted-out MSB takes part in the compare.
  always_comb begin
    t2     = {t, 1'b0};
    n_ext  = {1'b0, n};
    result = WIDTH'(t2);
    if (t2 >= n_ext) begin
      result = WIDTH'(t2 - n_ext);
    end
  end

endmodule

// File: rtl/modulo_product.sv
// Montgomery-domain entry: o_result = (y * 2^K) mod n, computed as K
// serial modular doublings, one per clock.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | waiting for i_start; operands latched on acceptance
//   S_PREP   | reduce y (< 2n) once into t < n, clear counter
//   S_RUN    | K cycles of t <= 2t mod n
//   S_FINISH | publish t on o_result, pulse o_finished
module modulo_product
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int K     = 256
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  modulo_product_if.slave bus
);

  localparam int            CW   = $clog2(K + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  modprod_state_e   state;
  modprod_state_e   state_nx;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_dbl;
  logic [WIDTH-1:0] result_r;
  logic             finished_r;
  logic             do_load;
  logic             do_prep;
  logic             do_run;
  logic             do_finish;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and per-state datapath enables.
  always_comb begin
    state_nx  = state;
    do_load   = 1'b0;
    do_prep   = 1'b0;
    do_run    = 1'b0;
    do_finish = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_start) begin
          do_load  = 1'b1;
          state_nx = S_PREP;
        end
      end
      S_PREP: begin
        do_prep  = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        do_run = 1'b1;
        if (counter == LAST) begin
          state_nx = S_FINISH;
        end
      end
      S_FINISH: begin
        do_finish = 1'b1;
        state_nx  = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  mod_double #(
    .WIDTH (WIDTH)
  ) u_mod_double (
    .t      (t),
    .n      (n_r),
    .result (t_dbl)
  );

  // Operand capture, reduction, doubling loop and result publication.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_r        <= '0;
      y_r        <= '0;
      t          <= '0;
      counter    <= '0;
      result_r   <= '0;
      finished_r <= 1'b0;
    end else begin
      finished_r <= 1'b0;
      if (do_load) begin
        n_r <= bus.i_n;
        y_r <= bus.i_y;
      end
      if (do_prep) begin
        t       <= (y_r >= n_r) ? (y_r - n_r) : y_r;
        counter <= '0;
      end
      if (do_run) begin
        t       <= t_dbl;
        counter <= counter + 1'b1;
      end
      if (do_finish) begin
        result_r   <= t;
        finished_r <= 1'b1;
      end
    end
  end

  assign bus.o_result   = result_r;
  assign bus.o_finished = finished_r;
  assign bus.o_busy     = (state != S_IDLE);

endmodule

// File: tb/tb_modulo_product.sv
// Bench for modulo_product: an 8-bit/K=8 instance checked every cycle
// against a transaction-level model, plus a 256-bit/K=256 instance
// checked per operation against wide-integer arithmetic.
module tb_modulo_product;

  logic clk;
  logic rst_n;

  int passed = 0;
  int total  = 0;

  modulo_product_if #(.WIDTH(8))   bus8  ();
  modulo_product_if #(.WIDTH(256)) bus256 ();

  modulo_product #(.WIDTH(8), .K(8)) dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus8)
  );

  modulo_product #(.WIDTH(256), .K(256)) dut256 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the definition (y * 2^K) mod n.
  function automatic logic [7:0] mp8(input logic [7:0] n, input logic [7:0] y);
    int p;
    p = int'(y) * 256;
    return 8'(p % int'(n));
  endfunction

  function automatic logic [255:0] mp256(input logic [255:0] n, input logic [255:0] y);
    logic [511:0] p;
    p = {y, 256'b0};
    return 256'(p % {256'b0, n});
  endfunction

  // Transaction model for the 8-bit instance: accepts a request only when
  // no operation is outstanding, finishes K+2 edges later.
  bit         m_active;
  int         m_cyc;
  int         m_done_edge;
  logic [7:0] m_exp;
  logic [7:0] m_res;
  bit         m_fin;
  bit         chk_en;

  always @(posedge clk) begin
    m_cyc++;
    if (!rst_n) begin
      m_active = 0;
      m_res    = '0;
      m_fin    = 0;
    end else begin
      m_fin = 0;
      if (!m_active && bus8.i_start) begin
        m_active    = 1;
        m_done_edge = m_cyc + 8 + 2;
        m_exp       = mp8(bus8.i_n, bus8.i_y);
      end
      if (m_active && m_cyc == m_done_edge) begin
        m_active = 0;
        m_fin    = 1;
        m_res    = m_exp;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cyc busy",     256'(bus8.o_busy),     256'(m_active));
      check("cyc finished", 256'(bus8.o_finished), 256'(m_fin));
      check("cyc result",   256'(bus8.o_result),   256'(m_res));
    end
  end

  // Drive a one-cycle request; returns at the negedge after the accepting edge.
  task automatic start8(input logic [7:0] n, input logic [7:0] y);
    @(negedge clk);
    bus8.i_start = 1'b1;
    bus8.i_n     = n;
    bus8.i_y     = y;
    @(negedge clk);
    bus8.i_start = 1'b0;
    bus8.i_n     = 8'($urandom);
    bus8.i_y     = 8'($urandom);
  endtask

  task automatic wait_fin8(input int k0, output int k);
    k = k0;
    while (!bus8.o_finished && k < k0 + 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic op8(input logic [7:0] n, input logic [7:0] y, input logic [7:0] lit, input string tag);
    int k;
    start8(n, y);
    wait_fin8(0, k);
    check({tag, " latency"}, 256'(k), 256'(10));
    check({tag, " result"}, 256'(bus8.o_result), 256'(lit));
  endtask

  task automatic op256(input logic [255:0] n, input logic [255:0] y, input string tag);
    int k;
    @(negedge clk);
    bus256.i_start = 1'b1;
    bus256.i_n     = n;
    bus256.i_y     = y;
    @(negedge clk);
    bus256.i_start = 1'b0;
    bus256.i_n     = '0;
    bus256.i_y     = '0;
    k = 0;
    while (!bus256.o_finished && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 256'(k), 256'(258));
    check({tag, " result"}, bus256.o_result, mp256(n, y));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = $urandom;
    end
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int p[3];
    int np;
    int k;
    logic [255:0] bn;
    logic [255:0] by;
    logic [256:0] two_n;

    chk_en         = 0;
    rst_n          = 1'b0;
    bus8.i_start   = 1'b0;
    bus8.i_n       = '0;
    bus8.i_y       = '0;
    bus256.i_start = 1'b0;
    bus256.i_n     = '0;
    bus256.i_y     = '0;
    repeat (3) @(negedge clk);

    check("reset result",   256'(bus8.o_result),     256'(0));
    check("reset finished", 256'(bus8.o_finished),   256'(0));
    check("reset busy",     256'(bus8.o_busy),       256'(0));
    check("reset busy256",  256'(bus256.o_busy),     256'(0));
    check("reset res256",   bus256.o_result,         256'(0));

    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1;

    // Hand-computed pins on the reference arithmetic itself.
    check("model 13,5",    256'(mp8(8'd13, 8'd5)),    256'(6));
    check("model 251,250", 256'(mp8(8'd251, 8'd250)), 256'(246));
    check("model256 13,5", mp256(256'd13, 256'd5),    256'(2));

    // Basic operations, including y >= N and the y = 2N-1 edge.
    op8(8'd13,  8'd5,   8'd6,   "n13 y5");
    op8(8'd13,  8'd20,  8'd11,  "n13 y20");
    op8(8'd251, 8'd250, 8'd246, "n251 y250");
    op8(8'd13,  8'd0,   8'd0,   "n13 y0");
    op8(8'd13,  8'd25,  8'd4,   "n13 y25");
    op8(8'd3,   8'd5,   8'd2,   "n3 y5");

    // A request during the run is ignored; only one pulse, result 6 sticks.
    start8(8'd13, 8'd5);
    repeat (3) @(negedge clk);
    bus8.i_start = 1'b1;
    bus8.i_n     = 8'd251;
    bus8.i_y     = 8'd250;
    @(negedge clk);
    bus8.i_start = 1'b0;
    wait_fin8(4, k);
    check("ignored latency", 256'(k), 256'(10));
    check("ignored result",  256'(bus8.o_result), 256'(6));
    repeat (15) @(negedge clk);
    check("ignored hold",    256'(bus8.o_result), 256'(6));

    // Start held high: back-to-back operations every K+3 clocks.
    p  = '{0, 0, 0};
    np = 0;
    @(negedge clk);
    bus8.i_start = 1'b1;
    bus8.i_n     = 8'd251;
    bus8.i_y     = 8'd1;
    for (int i = 0; i < 60 && np < 3; i++) begin
      @(negedge clk);
      if (bus8.o_finished) begin
        p[np] = i;
        np++;
        if (np == 3) bus8.i_start = 1'b0;
      end
    end
    bus8.i_start = 1'b0;
    check("b2b pulses",  256'(np),          256'(3));
    check("b2b first",   256'(p[0]),        256'(10));
    check("b2b gap1",    256'(p[1] - p[0]), 256'(11));
    check("b2b gap2",    256'(p[2] - p[1]), 256'(11));
    check("b2b result",  256'(bus8.o_result), 256'(5));
    repeat (5) @(negedge clk);

    // Reset mid-run: outputs clear at once, the aborted result never appears.
    start8(8'd13, 8'd5);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort result",   256'(bus8.o_result),   256'(0));
    check("abort finished", 256'(bus8.o_finished), 256'(0));
    check("abort busy",     256'(bus8.o_busy),     256'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    op8(8'd13, 8'd5, 8'd6, "after abort");

    // Full-width instance.
    op256(256'd13, 256'd5, "w256 pin");
    check("w256 pin lit", bus256.o_result, 256'(2));
    for (int i = 0; i < 40; i++) begin
      bn    = rand256();
      bn[0] = 1'b1;
      if (bn < 256'd3) bn = 256'd3;
      if (i < 3) bn[255] = 1'b0;
      two_n = {1'b0, bn} << 1;
      case (i)
        0:       by = '0;
        1:       by = bn;
        2:       by = 256'(two_n - 257'd1);
        default: by = 256'({1'b0, rand256()} % two_n);
      endcase
      op256(bn, by, "w256 rand");
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
